// File: rtl/dmem_responder_if.sv
// dmem_if: request/response channel between the CPU data port and the
// multi-cycle data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: one-request-at-a-time data memory with a fixed response
// latency of LATENCY cycles (2..15) and 2**DEPTH_W 16-bit words.
// Optional macro DMEM_ALIGN_CHECK_EN: odd byte addresses skip the storage
// access and respond with rdata 0 and err 1.
//
// state | meaning
// IDLE  | ready; a valid request is captured and the countdown loaded
// WAIT  | countdown; storage read/written on the edge leaving WAIT
// RESP  | single-cycle response strobe, then back to IDLE
module dmem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH_W = 12
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [DEPTH_W-1:0] idx_q, idx_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               access;
    logic               drop;
    logic               addr_unused;

    logic [15:0] mem_q [0:(1<<DEPTH_W)-1];

    // Only a slice of the byte address selects the word; the rest aliases.
    assign addr_unused = ^bus.req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic err_q, err_d;

    assign mis_d = (state_q == IDLE && bus.req_valid) ? bus.req_addr[0] : mis_q;
    assign err_d = access ? mis_q : err_q;
    assign drop  = mis_q;

    // Misalignment flag captured at acceptance, reported with the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign drop    = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Next-state, countdown and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    wr_d    = bus.req_wr;
                    idx_d   = bus.req_addr[DEPTH_W:1];
                    wdata_d = bus.req_wdata;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                    rdata_d = (wr_q || drop) ? 16'h0000 : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never reset; a store commits only on the edge entering RESP,
    // which cannot occur while reset holds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (access && wr_q && !drop) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a cycle-level model (acceptance cycle + LATENCY)
// checks the LATENCY=4 instance every cycle; directed literals pin the model
// and exercise a second LATENCY=2 instance.
module tb_dmem_responder;
    localparam int LAT  = 4;
    localparam int LAT2 = 2;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic        EXP_MIS_ERR = 1'b1;
    localparam logic [15:0] EXP_W30     = 16'h1111;
`else
    localparam logic        EXP_MIS_ERR = 1'b0;
    localparam logic [15:0] EXP_W30     = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    dmem_if bus ();
    dmem_if bus2 ();

    dmem_responder #(.LATENCY(LAT), .DEPTH_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.LATENCY(LAT2), .DEPTH_W(12)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- model of the LATENCY=4 instance ----------------
    logic [15:0] mem_m [int];
    int          rsp_c = -1;
    int          free_c = 0;
    logic        p_wr = 1'b0;
    logic        p_mis = 1'b0;
    int          p_idx = 0;
    logic [15:0] p_wdata = 16'h0;
    logic [15:0] last_rd = 16'h0;
    bit          last_known = 1'b1;
    logic        last_err = 1'b0;
    bit          exp_ready;
    bit          exp_valid;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready", bus.req_ready, 1);
            check("rst_valid", bus.rsp_valid, 0);
            check("rst_rdata", bus.rsp_rdata, 0);
            check("rst_busy",  bus.busy, 0);
            check("rst_err",   bus.err, 0);
            rsp_c      = -1;
            free_c     = 0;
            last_rd    = 16'h0;
            last_known = 1'b1;
            last_err   = 1'b0;
        end else begin
            exp_ready = (cyc >= free_c);
            exp_valid = (cyc == rsp_c);
            if (exp_valid) begin
                last_err   = p_mis;
                last_known = 1'b1;
                if (p_mis) begin
                    last_rd = 16'h0;
                end else if (p_wr) begin
                    mem_m[p_idx] = p_wdata;
                    last_rd = 16'h0;
                end else if (mem_m.exists(p_idx)) begin
                    last_rd = mem_m[p_idx];
                end else begin
                    last_known = 1'b0;
                end
            end
            check("ready", bus.req_ready, exp_ready);
            check("busy", bus.busy, !exp_ready);
            check("rsp_valid", bus.rsp_valid, exp_valid);
            if (last_known) check("rdata", bus.rsp_rdata, last_rd);
            if (exp_valid) check("err", bus.err, last_err);
            if (exp_ready && bus.req_valid) begin
                p_wr    = bus.req_wr;
                p_idx   = int'((bus.req_addr >> 1) & 16'h0FFF);
                p_wdata = bus.req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
                p_mis   = bus.req_addr[0];
`else
                p_mis   = 1'b0;
`endif
                rsp_c  = cyc + LAT;
                free_c = cyc + LAT + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int sel, input logic v, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus.req_valid = v; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_wr = wr; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int sel, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, output int t);
        int   budget;
        logic rdy;
        budget = 40;
        t = -1;
        drive(sel, 1'b1, wr, a, d);
        while (t < 0 && budget > 0) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus.req_ready : bus2.req_ready;
            if (rdy === 1'b1) t = cyc;
            @(posedge clk);
            #1;
            budget--;
        end
        drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
        if (t < 0) fail_now("accept");
    endtask

    // Waits for cycle t+LAT on the main instance, checks it, then resyncs.
    task automatic expect_rsp(input string name, input int t, input logic [15:0] rd, input logic er);
        int budget;
        budget = 40;
        while (cyc < t + LAT && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (cyc != t + LAT) begin
            fail_now(name);
        end else begin
            check({name, "_valid"}, bus.rsp_valid, 1);
            check({name, "_rdata"}, bus.rsp_rdata, rd);
            check({name, "_err"}, bus.err, er);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int t, t1, t2;

    initial begin
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // store then load
        send(0, 1'b1, 16'h0010, 16'hBEEF, t);
        expect_rsp("st_beef", t, 16'h0000, 1'b0);
        send(0, 1'b0, 16'h0010, 16'h0000, t);
        expect_rsp("ld_beef", t, 16'hBEEF, 1'b0);

        // back-to-back loads with request held
        send(0, 1'b1, 16'h0002, 16'hA002, t);
        expect_rsp("st_a002", t, 16'h0000, 1'b0);
        send(0, 1'b1, 16'h0004, 16'hA004, t);
        expect_rsp("st_a004", t, 16'h0000, 1'b0);
        send(0, 1'b0, 16'h0002, 16'h0000, t1);
        send(0, 1'b0, 16'h0004, 16'h0000, t2);
        check("b2b_spacing", t2 - t1, 5);
        expect_rsp("ld_a004", t2, 16'hA004, 1'b0);

        // aliasing above DEPTH_W
        send(0, 1'b1, 16'h2006, 16'h1234, t);
        expect_rsp("st_alias", t, 16'h0000, 1'b0);
        send(0, 1'b0, 16'h0006, 16'h0000, t);
        expect_rsp("ld_alias", t, 16'h1234, 1'b0);

        // reset during WAIT of a store
        send(0, 1'b1, 16'h0020, 16'h5555, t);
        expect_rsp("st_5555", t, 16'h0000, 1'b0);
        send(0, 1'b0, 16'h0020, 16'h0000, t);
        expect_rsp("ld_5555a", t, 16'h5555, 1'b0);
        send(0, 1'b1, 16'h0020, 16'hAAAA, t);
        sync();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.rsp_valid, 0);
        check("midrst_rdata", bus.rsp_rdata, 16'h0000);
        check("midrst_busy", bus.busy, 0);
        sync();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(0, 1'b0, 16'h0020, 16'h0000, t);
        expect_rsp("ld_5555b", t, 16'h5555, 1'b0);

        // odd address
        send(0, 1'b1, 16'h0030, 16'h1111, t);
        expect_rsp("st_1111", t, 16'h0000, 1'b0);
        send(0, 1'b1, 16'h0031, 16'hFFFF, t);
        expect_rsp("st_odd", t, 16'h0000, EXP_MIS_ERR);
        send(0, 1'b0, 16'h0030, 16'h0000, t);
        expect_rsp("ld_w30", t, EXP_W30, 1'b0);

        // LATENCY=2 instance
        send(1, 1'b1, 16'h0040, 16'h7E57, t);
        @(negedge clk);
        check("l2_wait_valid", bus2.rsp_valid, 0);
        check("l2_wait_busy", bus2.busy, 1);
        check("l2_wait_ready", bus2.req_ready, 0);
        @(negedge clk);
        check("l2_st_cycle", cyc - t, 2);
        check("l2_st_valid", bus2.rsp_valid, 1);
        check("l2_st_rdata", bus2.rsp_rdata, 16'h0000);
        @(negedge clk);
        check("l2_idle_valid", bus2.rsp_valid, 0);
        check("l2_idle_ready", bus2.req_ready, 1);
        sync();
        send(1, 1'b0, 16'h0040, 16'h0000, t);
        @(negedge clk);
        check("l2_ld_wait", bus2.rsp_valid, 0);
        @(negedge clk);
        check("l2_ld_cycle", cyc - t, 2);
        check("l2_ld_valid", bus2.rsp_valid, 1);
        check("l2_ld_rdata", bus2.rsp_rdata, 16'h7E57);
        @(negedge clk);
        check("l2_hold_rdata", bus2.rsp_rdata, 16'h7E57);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder sitting on the CPU's data-memory port. It accepts one load or store at a time through a valid/ready request channel. It returns a one-cycle response after a fixed, parameterised latency, and holds the word-addressed data storage. It replaces the single-cycle data memory for the multi-cycle memory phase; the CPU stalls on `req_ready`/`rsp_valid`.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the response cycle; legal range 2..15.
- `DEPTH_W`, default 12: log2 of storage words; the word index is `req_addr[DEPTH_W:1]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req_valid`  in  1  request present.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  byte address; bits above `DEPTH_W` are ignored.
- `req_wdata`  in  16  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle response strobe for every accepted request, loads and stores alike.
- `rsp_rdata`  out  16  load data; valid while `rsp_valid` is high.
- `busy`  out  1  a request is in flight: state WAIT or RESP.
- `err`  out  1  alignment error flag, qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1 (combinational from state only).
  - When `req_valid`=1, accept: latch `req_wr`, the word index, and `req_wdata`; load the down-counter with LATENCY-2; go to WAIT.
  - When `req_valid`=0, stay in IDLE.
- WAIT:
  - `req_ready`=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, go to RESP. On that same edge:
    - load: `rsp_rdata` <= mem[index];
    - store: mem[index] <= latched wdata, and `rsp_rdata` <= 16'h0000.
- RESP: `rsp_valid`=1 and `req_ready`=0 for exactly one cycle; then go to IDLE unconditionally.
- `req_valid` is ignored outside IDLE. Requests offered then are neither queued nor dropped silently: the requester must hold them until `req_ready`=1.
- A request offered in the RESP cycle is therefore accepted no earlier than the following IDLE cycle.
- `rsp_rdata` holds its last value outside RESP.
- Storage is not cleared by reset; its contents are undefined until written.
- Reset mid-operation:
  - FSM goes to IDLE immediately and the in-flight request is abandoned.
  - A store is not committed unless the edge entering RESP has already occurred.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=16'h0000, `busy`=0, `err`=0, counter 0, state IDLE.

## Timing
- Request accepted on edge E (cycle T: `req_valid`=`req_ready`=1).
- WAIT occupies cycles T+1 .. T+LATENCY-1.
- RESP cycle is T+LATENCY, with `rsp_valid`=1 and data/err valid.
- Earliest next acceptance is cycle T+LATENCY+1, so throughput is one request per LATENCY+1 cycles.
- A store is visible to a load accepted in any later cycle; there is no read-during-write hazard because only one request is in flight.
- `busy` is registered with the state; it equals !`req_ready`.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A request with `req_addr[0]`=1 still runs the full FSM and latency.
  - It performs no storage access, so a store is dropped.
  - The response carries `rsp_rdata`=16'h0000 and `err`=1.
  - `err`=0 on aligned responses.
- `DMEM_ALIGN_CHECK_EN` undefined: `req_addr[0]` is ignored, `err` is tied to 0, and the check logic is absent.

## Test plan
- Reset, then store 16'hBEEF to 0x0010 (LATENCY=4) -> `rsp_valid` high only in cycle T+4 with `rsp_rdata`=0. Then load 0x0010 -> `rsp_rdata`=16'hBEEF in its T+4.
- Back-to-back: hold `req_valid` continuously with loads of 0x0002 then 0x0004 -> second acceptance exactly 5 cycles after the first; `req_ready`=0 throughout WAIT/RESP; exactly one `rsp_valid` pulse per request.
- Address aliasing with DEPTH_W=12: store 16'h1234 to 0x2006, then load 0x0006 -> 16'h1234.
- Reset asserted in WAIT during a store of 16'hAAAA to 0x0020, which previously held 16'h5555 -> no `rsp_valid`; outputs at reset values; a subsequent load of 0x0020 returns 16'h5555.
- With `DMEM_ALIGN_CHECK_EN`: store 16'hFFFF to 0x0031 -> `err`=1 in RESP; load 0x0030 returns its prior value unchanged. Without the macro: same stimulus writes word 0x0030 and `err` stays 0.
- LATENCY=2: a load is accepted in cycle T, WAIT lasts one cycle, and `rsp_valid` is high in cycle T+2.
